// File: rtl/mc_resp_pkg.sv
// Shared constants, state types and sizing helper for the MC-side AXI responder.
package mc_resp_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mc_resp_mem.sv
// Simple dual-port word array: byte-enabled write port, registered read port (read-before-write).
module mc_resp_mem #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IDX_W-1:0]    waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                re,
   input  logic [IDX_W-1:0]    raddr,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Array is deliberately not reset so contents survive a mid-burst reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_mc_responder.sv
// AXI4 slave modelling the memory-controller end of the MC port: independent write/read FSMs over one array.
// Optional MC_RESP_BACKPRESSURE_EN adds LFSR-driven wready/rvalid throttling.
module axi_mc_responder
   import mc_resp_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned READ_LAT  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);

   localparam int unsigned IDX_W = idx_width(MEM_DEPTH);
   localparam int unsigned OFF_W = idx_width(DATA_W/8);
   localparam int unsigned LAT_W = idx_width(READ_LAT + 1);

   w_state_t          w_state, w_state_nxt;
   r_state_t          r_state, r_state_nxt;
   logic              alive;
   logic              w_gate, r_gate;
   logic [ID_W-1:0]   w_id, r_id;
   logic [IDX_W-1:0]  w_idx, r_idx;
   logic [7:0]        w_len, w_cnt, r_len, r_beat;
   logic              w_over, r_shown;
   logic [1:0]        bresp_q;
   logic [LAT_W-1:0]  lat_cnt;
   logic              aw_hs, w_hs, ar_hs, r_hs;
   logic              mem_re;
   logic [IDX_W-1:0]  mem_raddr;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{awaddr, araddr};

`ifdef MC_RESP_BACKPRESSURE_EN
   logic [7:0] lfsr;
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 8'hA5;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign w_gate = (lfsr[1:0] != 2'b00);
   assign r_gate = (lfsr[3:2] != 2'b00);
`else
   assign w_gate = 1'b1;
   assign r_gate = 1'b1;
`endif

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;
   assign r_hs  = rvalid && rready;

   // Readies stay low until the first clock after reset is released.
   always_ff @(posedge clk) begin
      if (rst) alive <= 1'b0;
      else     alive <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_over  <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         w_state <= w_state_nxt;
         if (aw_hs) begin
            w_id   <= awid;
            w_idx  <= awaddr[OFF_W +: IDX_W];
            w_len  <= awlen;
            w_cnt  <= '0;
            w_over <= 1'b0;
         end
         if (w_hs) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt + 8'd1;
            // Sticky so an overlong burst stays SLVERR even if the count wraps.
            if (!wlast && (w_cnt == w_len)) w_over <= 1'b1;
            if (wlast) bresp_q <= ((w_cnt == w_len) && !w_over) ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      awready     = 1'b0;
      wready      = 1'b0;
      bvalid      = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = alive;
            if (awvalid && alive) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            wready = w_gate;
            if (wvalid && w_gate && wlast) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   assign bid   = w_id;
   assign bresp = bresp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         lat_cnt <= '0;
         r_shown <= 1'b0;
      end else begin
         r_state <= r_state_nxt;
         r_shown <= rvalid && !rready;
         if (ar_hs) begin
            r_id    <= arid;
            r_idx   <= araddr[OFF_W +: IDX_W];
            r_len   <= arlen;
            r_beat  <= '0;
            lat_cnt <= LAT_W'(READ_LAT);
         end
         if (r_state == R_WAIT) lat_cnt <= lat_cnt - LAT_W'(1);
         if (r_hs) begin
            r_idx  <= r_idx + IDX_W'(1);
            r_beat <= r_beat + 8'd1;
         end
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      arready     = 1'b0;
      rvalid      = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = alive;
            if (arvalid && alive) r_state_nxt = R_WAIT;
         end
         R_WAIT: begin
            if (lat_cnt == LAT_W'(1)) r_state_nxt = R_DATA;
         end
         R_DATA: begin
            rvalid = r_shown || r_gate;
            if ((r_shown || r_gate) && rready && (r_beat == r_len)) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   assign rlast = rvalid && (r_beat == r_len);
   assign rid   = r_id;
   assign rresp = RESP_OKAY;

   // Prefetch: fetch the first word in the last wait cycle, then the next word on each non-final handshake.
   assign mem_re    = ((r_state == R_WAIT) && (lat_cnt == LAT_W'(1))) || (r_hs && !rlast);
   assign mem_raddr = (r_state == R_DATA) ? r_idx + IDX_W'(1) : r_idx;

   mc_resp_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (w_hs),
      .waddr (w_idx),
      .wdata (wdata),
      .wstrb (wstrb),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_axi_mc_responder.sv
// Randomized self-checking bench for axi_mc_responder against a word-array reference model.
module tb_axi_mc_responder;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 128;
   localparam int unsigned ID_W      = 4;
   localparam int unsigned MEM_DEPTH = 256;
   localparam int unsigned READ_LAT  = 2;
   localparam int unsigned STRB_W    = DATA_W/8;
   localparam int unsigned OFF_W     = $clog2(STRB_W);
   localparam int unsigned TMO       = 200;

   logic                clk = 1'b0;
   logic                rst;
   logic [ID_W-1:0]     awid, arid, bid, rid;
   logic [ADDR_W-1:0]   awaddr, araddr;
   logic [7:0]          awlen, arlen;
   logic                awvalid, awready, wlast, wvalid, wready;
   logic [DATA_W-1:0]   wdata, rdata;
   logic [STRB_W-1:0]   wstrb;
   logic [1:0]          bresp, rresp;
   logic                bvalid, bready, arvalid, arready, rlast, rvalid, rready;

   logic [DATA_W-1:0]   model [MEM_DEPTH];
   int unsigned         cyc = 0;
   int unsigned         n_vec = 0;
   int unsigned         n_err = 0;

   axi_mc_responder #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .ID_W      (ID_W),
      .MEM_DEPTH (MEM_DEPTH),
      .READ_LAT  (READ_LAT)
   ) dut (
      .clk (clk), .rst (rst),
      .awid (awid), .awaddr (awaddr), .awlen (awlen), .awvalid (awvalid), .awready (awready),
      .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
      .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready),
      .arid (arid), .araddr (araddr), .arlen (arlen), .arvalid (arvalid), .arready (arready),
      .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // dmode: 0 = beat number + 1, 1 = random data/strobes with gaps, 2 = all ones, 3 = all zeros.
   // abort_at >= 0 pulses reset instead of sending that beat.
   task automatic wr_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int unsigned len, input int unsigned nbeats, input int dmode,
                           input logic [STRB_W-1:0] strb, input int abort_at);
      int unsigned base, c, w;
      logic [DATA_W-1:0] d;
      logic [STRB_W-1:0] s;
      base = (addr >> OFF_W) % MEM_DEPTH;
      awid = id; awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
      c = 0;
      while (!awready && c < TMO) begin @(posedge clk); #1; c++; end
      if (c >= TMO) begin check("aw_timeout", 0, 1); awvalid = 1'b0; return; end
      @(posedge clk); #1;
      awvalid = 1'b0;
`ifndef MC_RESP_BACKPRESSURE_EN
      check("wready_after_aw", wready, 1);
`endif
      for (int k = 0; k < int'(nbeats); k++) begin
         if (abort_at == k) begin
            wvalid = 1'b0; rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            check("bvalid_after_abort", bvalid, 0);
            check("wready_after_abort", wready, 0);
            @(posedge clk); #1;
            check("awready_after_abort", awready, 1);
            return;
         end
         case (dmode)
            0: d = DATA_W'(k + 1);
            1: d = rand_word();
            2: d = '1;
            default: d = '0;
         endcase
         s = (dmode == 1) ? STRB_W'($urandom) : strb;
         wdata = d; wstrb = s; wlast = (k == int'(nbeats) - 1); wvalid = 1'b1;
         c = 0;
         while (!wready && c < TMO) begin @(posedge clk); #1; c++; end
         if (c >= TMO) begin check("w_timeout", 0, 1); wvalid = 1'b0; return; end
         @(posedge clk); #1;
         w = (base + k) % MEM_DEPTH;
         for (int b = 0; b < int'(STRB_W); b++)
            if (s[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
         wvalid = 1'b0; wlast = 1'b0;
         if (dmode == 1 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      check("bvalid_after_wlast", bvalid, 1);
      check("bid", bid, id);
      check("bresp", bresp, (nbeats == len + 1) ? 2'b00 : 2'b10);
      repeat ($urandom_range(0, 3)) begin
         @(posedge clk); #1;
         check("bvalid_hold", bvalid, 1);
         check("bid_hold", bid, id);
      end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check("awready_after_b", awready, 1);
   endtask

   task automatic rd_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input int unsigned len, input int unsigned stall_first, input bit rnd);
      int unsigned base, c, k, ar_cyc, stall_left;
      bit first, prev_stall;
      base = (addr >> OFF_W) % MEM_DEPTH;
      arid = id; araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
      c = 0;
      while (!arready && c < TMO) begin @(posedge clk); #1; c++; end
      if (c >= TMO) begin check("ar_timeout", 0, 1); arvalid = 1'b0; return; end
      @(posedge clk); #1;
      arvalid = 1'b0;
      ar_cyc = cyc;
      k = 0; c = 0; first = 1'b1; prev_stall = 1'b0; stall_left = stall_first;
      while (k <= len && c < TMO) begin
         if (prev_stall) check("rvalid_hold", rvalid, 1);
         if (rvalid) begin
`ifndef MC_RESP_BACKPRESSURE_EN
            if (first) check("r_latency", cyc - ar_cyc, READ_LAT);
`endif
            first = 1'b0;
            check("rid", rid, id);
            check("rdata", rdata, model[(base + k) % MEM_DEPTH]);
            check("rlast", rlast, (k == len));
            check("rresp", rresp, 2'b00);
            if (stall_left > 0) begin rready = 1'b0; stall_left--; end
            else rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_stall = !rready;
            if (rready) k++;
         end else begin
            rready = rnd ? $urandom_range(0, 1) : 1'b1;
            prev_stall = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      rready = 1'b0;
      if (c >= TMO) check("r_timeout", 0, 1);
      else          check("arready_after_rlast", arready, 1);
   endtask

   initial begin
      int unsigned len, nb;
      rst = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_awready", awready, 0);
         check("rst_arready", arready, 0);
         check("rst_wready", wready, 0);
         check("rst_bvalid", bvalid, 0);
         check("rst_rvalid", rvalid, 0);
      end
      check("rst_rlast", rlast, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      check("rst_bid", bid, 0);
      check("rst_rid", rid, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("awready_after_rst", awready, 1);
      check("arready_after_rst", arready, 1);

      // Fill the whole array so every word is known to the model.
      wr_burst(4'd0, 32'h0, 255, 256, 1, '1, -1);

      wr_burst(4'd3, 32'h40, 3, 4, 0, '1, -1);
      rd_burst(4'd5, 32'h40, 3, 0, 1'b0);

      wr_burst(4'd6, 32'h40, 3, 2, 1, '1, -1);
      rd_burst(4'd6, 32'h40, 3, 0, 1'b0);

      wr_burst(4'd1, 32'h0, 0, 1, 2, '1, -1);
      wr_burst(4'd1, 32'h0, 0, 1, 3, 16'h000F, -1);
      rd_burst(4'd1, 32'h0, 0, 0, 1'b0);

      rd_burst(4'd9, ADDR_W'((MEM_DEPTH - 1) << OFF_W), 1, 5, 1'b0);

      wr_burst(4'd7, 32'hFFFF_F0A7, 1, 3, 0, '1, -1);
      rd_burst(4'd7, 32'h0000_00A0, 2, 0, 1'b1);

      wr_burst(4'd2, 32'h40, 3, 4, 1, '1, 2);
      rd_burst(4'd2, 32'h40, 3, 0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         len = $urandom_range(0, 15);
         case ($urandom_range(0, 5))
            0:       nb = (len > 0) ? len : 1;
            1:       nb = len + 2;
            default: nb = len + 1;
         endcase
         wr_burst(ID_W'($urandom), $urandom, len, nb, 1, '1, -1);
         rd_burst(ID_W'($urandom), $urandom, $urandom_range(0, 15), $urandom_range(0, 2), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_mc_responder.md
# axi_mc_responder

Synthesizable AXI4 slave that models the memory-controller end of the compressor's MC-side AXI port. It replaces the W→R loopback used in system simulation. It accepts write bursts (AW/W) into an internal word array and returns B responses. It serves read bursts (AR) from the same array on R with a programmable latency. Write and read paths are independent FSMs sharing one simple-dual-port memory.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 128, data beat width (power of two, ≥32)
- ID_W, 4, transaction ID width
- MEM_DEPTH, 256, array depth in DATA_W words (power of two)
- READ_LAT, 2, cycles between AR handshake and first R beat (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- awid/awaddr/awlen/awvalid  in  ID_W/ADDR_W/8/1  write address channel
- awready  out  1  write address ready
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data channel
- wready  out  1  write data ready
- bid/bresp/bvalid  out  ID_W/2/1  write response
- bready  in  1  response ready
- arid/araddr/arlen/arvalid  in  ID_W/ADDR_W/8/1  read address channel
- arready  out  1  read address ready
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel
- rready  in  1  read data ready

## Operation
- Word index = addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]. Low byte-offset bits and high bits are ignored. All bursts are INCR; the index wraps modulo MEM_DEPTH.
- Write FSM, W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id, index and len, clear the beat count, and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes wdata under wstrb byte enables at the current index, then increments the index and the count.
  - On a handshake with wlast=1, go to W_RESP. bresp=OKAY(00) if count==awlen, else SLVERR(10). Beats after awlen+1 without wlast are still written, and the burst ends SLVERR.
  - W_RESP: bvalid=1, bid=latched id. Return to W_IDLE on the bready handshake.
- Read FSM, R_IDLE → R_WAIT → R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch id, index and len, and load the latency counter.
  - R_WAIT: count down READ_LAT cycles, then go to R_DATA.
  - R_DATA: rvalid=1, rresp=OKAY. rlast=1 on beat arlen. Each rready handshake advances the index and presents the next word. Return to R_IDLE after the rlast handshake.
- Valid signals never drop, and payloads never change, while valid=1 and ready=0.
- Same-cycle write and read of the same word: the read returns the old data (read-before-write).
- Reset: FSMs go to IDLE; counters and registered outputs clear. Array contents are not reset and persist across a mid-burst reset. A burst interrupted by reset is abandoned with no B or R.

## Timing
- Reset values: awready=wready=arready=0; bvalid=rvalid=rlast=0; bresp=rresp=00; bid=rid=0; rdata=0.
- awready=arready=1 in the first cycle after rst deasserts.
- AW handshake at cycle t → wready=1 at t+1.
- wlast handshake at t → bvalid=1 at t+1.
- B handshake at t → awready=1 at t+1.
- AR handshake at t → first rvalid at t+1+READ_LAT. With rready held high, later beats are back to back.
- rlast handshake at t → arready=1 at t+1.
- One outstanding transaction per direction; no ID reordering.

## Configuration
- MC_RESP_BACKPRESSURE_EN defined:
  - An 8-bit LFSR (seed 8'hA5, reset by rst) advances every cycle.
  - In W_DATA, wready is forced 0 when lfsr[1:0]==0.
  - In R_DATA, the next beat is withheld (rvalid held 0 before it is asserted) when lfsr[3:2]==0. An already-asserted rvalid is never withdrawn.
- Undefined: no LFSR; wready and rvalid follow the timing above exactly.

## Structure
- Package mc_resp_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write and read state enums.
  - Index width function clog2-based.
- Sub-module mc_resp_mem: MEM_DEPTH×DATA_W simple dual-port RAM with one byte-enabled write port and one registered read port, read-before-write. The read FSM prefetches so that the R timing above holds.

## Test plan
- Reset: rst high for 3 cycles → all readies and valids 0. First cycle after release → awready=arready=1.
- Write at awaddr=0x40, awlen=3, awid=3, wstrb all-ones, data 0x…01…0x…04 back to back → words 4–7 written; bvalid at wlast+1, bresp=00, bid=3.
- Read at araddr=0x40, arlen=3, arid=5, READ_LAT=2, rready=1 → rvalid at AR+3; data 0x…01…0x…04 on consecutive cycles; rlast only on beat 4; rid=5.
- Early wlast: awlen=3, wlast on beat 2 → bresp=10; only words 4,5 change, 6,7 keep their old values.
- Partial strobe: word 0 holds all-ones; write 0 with wstrb=0x000F → only bytes 0–3 become 0; read back confirms.
- Stall and wrap: araddr at word MEM_DEPTH-1, arlen=1, rready low for 5 cycles after the first rvalid → rdata, rlast and rid stable throughout; the second beat returns word 0 with rlast=1.
